// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite configuration sequencer.
//   resp_t          : AXI response encodings
//   err_code_t      : error codes reported by the sequencer
//   cfg_seq_state_t : top-level sequencer FSM states
//   AXI_*_W         : default AXI widths
package axi4_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_RESP_W = 2;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_RESP = 2'd1,
    ERR_MISMATCH = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_FINISH
  } cfg_seq_state_t;

endpackage

// File: rtl/axi4_lite_single_master.sv
// Single-outstanding AXI4-Lite master engine.
// A one-cycle req (we=1 write, we=0 read) launches one transaction; the engine
// runs the AW/W (or AR) handshakes and then waits for B (or R).
//   req/we/addr/wdata : command, sampled only when req is high
//   addr_done         : address phase (AW+W, or AR) completes this cycle
//   ack               : response phase ends this cycle (response or timeout)
//   timed_out         : the ack is a timeout, not a real response
//   resp/rdata        : response code and read data, valid with ack
//   m_*               : AXI4-Lite master channels, all valid/ready registered
module axi4_lite_single_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W  = AXI_ADDR_W,
  parameter int DATA_W  = AXI_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       req,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic                       addr_done,
  output logic                       ack,
  output logic                       timed_out,
  output logic [AXI_RESP_W-1:0]      resp,
  output logic [DATA_W-1:0]          rdata,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [ADDR_W-1:0]          m_awaddr,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  input  logic [AXI_RESP_W-1:0]      m_bresp,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  output logic [ADDR_W-1:0]          m_araddr,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic [AXI_RESP_W-1:0]      m_rresp
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  logic [TCNT_W-1:0] tcnt;
  logic              w_addr_done;
  logic              r_addr_done;
  logic              waiting;

  // AW and W retire independently; the write address phase ends in the cycle
  // the last still-pending valid handshakes.
  assign w_addr_done = (m_awvalid || m_wvalid) &&
                       (!m_awvalid || m_awready) &&
                       (!m_wvalid  || m_wready);
  assign r_addr_done = m_arvalid && m_arready;
  assign addr_done   = w_addr_done || r_addr_done;

  // Timeout fires on the cycle the counter would reach TIMEOUT, so the slave
  // gets exactly TIMEOUT cycles after entering the response phase.
  assign waiting   = (m_bready && !m_bvalid) || (m_rready && !m_rvalid);
  assign timed_out = waiting && (tcnt == TCNT_LAST);
  assign ack       = (m_bready && m_bvalid) || (m_rready && m_rvalid) || timed_out;
  assign resp      = m_rready ? m_rresp : m_bresp;
  assign rdata     = m_rdata;
  assign m_wstrb   = '1;

  // Handshake registers: valids drop only on their own handshake, readys are
  // held for the whole response phase.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_arvalid <= 1'b0;
      m_bready  <= 1'b0;
      m_rready  <= 1'b0;
      m_awaddr  <= '0;
      m_wdata   <= '0;
      m_araddr  <= '0;
      tcnt      <= '0;
    end else begin
      if (m_awvalid && m_awready) m_awvalid <= 1'b0;
      if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
      if (m_arvalid && m_arready) m_arvalid <= 1'b0;
      if (req && we) begin
        m_awvalid <= 1'b1;
        m_wvalid  <= 1'b1;
        m_awaddr  <= addr;
        m_wdata   <= wdata;
      end else if (req) begin
        m_arvalid <= 1'b1;
        m_araddr  <= addr;
      end
      if (waiting) tcnt <= tcnt + TCNT_W'(1);
      if (m_bready && (m_bvalid || timed_out)) m_bready <= 1'b0;
      if (m_rready && (m_rvalid || timed_out)) m_rready <= 1'b0;
      if (w_addr_done) begin
        m_bready <= 1'b1;
        tcnt     <= '0;
      end
      if (r_addr_done) begin
        m_rready <= 1'b1;
        tcnt     <= '0;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_cfg_sequencer.sv
// Boot/reconfiguration sequencer: walks a table of (address, data) entries,
// writes each one over AXI4-Lite and, with VERIFY set, reads it back and
// compares.
//   start/n_entries      : launch a run of n_entries entries (ignored unless idle)
//   busy/done            : run in progress / one-cycle completion pulse
//   error/err_code/err_idx : sticky failure report for the last run
//   tbl_idx -> tbl_addr/tbl_data : combinational table lookup
//   m_*                  : AXI4-Lite master port toward the CSR slave
module axi4_lite_cfg_sequencer
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W    = AXI_ADDR_W,
  parameter int DATA_W    = AXI_DATA_W,
  parameter int N_ENTRIES = 16,
  parameter int IDX_W     = $clog2(N_ENTRIES),
  parameter bit VERIFY    = 1'b1,
  parameter int TIMEOUT   = 255
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [IDX_W:0]        n_entries,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [IDX_W-1:0]      err_idx,
  output logic [IDX_W-1:0]      tbl_idx,
  input  logic [ADDR_W-1:0]     tbl_addr,
  input  logic [DATA_W-1:0]     tbl_data,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_W-1:0]     m_araddr,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp
);

  cfg_seq_state_t    state, state_n;
  err_code_t         err_code_q, err_n;
  logic [IDX_W:0]    n_last;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [ADDR_W-1:0] req_addr;
  logic              req, req_we;
  logic              addr_done, ack, timed_out;
  logic [1:0]        resp;
  logic [DATA_W-1:0] rdata;
  logic              accept, advance, set_err, last_entry;

  assign err_code = err_code_q;

  // The index stops at the configured count or the table depth, never wraps.
  assign last_entry = ({1'b0, tbl_idx} == n_last - (IDX_W+1)'(1)) ||
                      (tbl_idx == IDX_W'(N_ENTRIES - 1));

  axi4_lite_single_master #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_master (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req       (req),
    .we        (req_we),
    .addr      (req_addr),
    .wdata     (tbl_data),
    .addr_done (addr_done),
    .ack       (ack),
    .timed_out (timed_out),
    .resp      (resp),
    .rdata     (rdata),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_awaddr  (m_awaddr),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_bresp   (m_bresp),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_araddr  (m_araddr),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next state plus the one-cycle command/report strobes. A write command is
  // issued from LOAD with the live table entry; the verify read is issued the
  // cycle the write response is accepted, using the latched address.
  always_comb begin
    state_n  = state;
    req      = 1'b0;
    req_we   = 1'b0;
    req_addr = lat_addr;
    accept   = 1'b0;
    advance  = 1'b0;
    set_err  = 1'b0;
    err_n    = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (n_entries == '0) begin
            state_n = ST_FINISH;
          end else begin
            accept  = 1'b1;
            state_n = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        req      = 1'b1;
        req_we   = 1'b1;
        req_addr = tbl_addr;
        state_n  = ST_WADDR;
      end
      ST_WADDR: if (addr_done) state_n = ST_WRESP;
      ST_WRESP: begin
        if (ack) begin
          if (timed_out) begin
            set_err = 1'b1;
            err_n   = ERR_TIMEOUT;
          end else if (resp != RESP_OKAY) begin
            set_err = 1'b1;
            err_n   = ERR_BAD_RESP;
          end else if (VERIFY) begin
            req     = 1'b1;
            state_n = ST_RADDR;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_RADDR: if (addr_done) state_n = ST_RDATA;
      ST_RDATA: begin
        if (ack) begin
          if (timed_out) begin
            set_err = 1'b1;
            err_n   = ERR_TIMEOUT;
          end else if (resp != RESP_OKAY) begin
            set_err = 1'b1;
            err_n   = ERR_BAD_RESP;
          end else if (rdata != lat_data) begin
            set_err = 1'b1;
            err_n   = ERR_MISMATCH;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
    if (set_err)      state_n = ST_FINISH;
    else if (advance) state_n = last_entry ? ST_FINISH : ST_LOAD;
  end

  // busy/done follow the next state so they line up with the state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code_q <= ERR_NONE;
      err_idx    <= '0;
      tbl_idx    <= '0;
      n_last     <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
    end else begin
      busy <= (state_n != ST_IDLE) && (state_n != ST_FINISH);
      done <= (state_n == ST_FINISH);
      if (accept) begin
        tbl_idx    <= '0;
        n_last     <= n_entries;
        error      <= 1'b0;
        err_code_q <= ERR_NONE;
        err_idx    <= '0;
      end
      if (state == ST_LOAD) begin
        lat_addr <= tbl_addr;
        lat_data <= tbl_data;
      end
      if (advance && !last_entry) tbl_idx <= tbl_idx + IDX_W'(1);
      if (set_err) begin
        error      <= 1'b1;
        err_code_q <= err_n;
        err_idx    <= tbl_idx;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_cfg_sequencer.sv
// Directed bench for axi4_lite_cfg_sequencer with a small AXI4-Lite slave
// model (register array, programmable AW/W delays and faults).
module tb_axi4_lite_cfg_sequencer;

  logic        aclk, aresetn, start;
  logic [4:0]  n_entries;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [3:0]  err_idx, tbl_idx;
  logic [31:0] tbl_addr, tbl_data;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  int total, bad;

  // table, written only by the tests
  logic [31:0] tbl_a [16];
  logic [31:0] tbl_d [16];
  assign tbl_addr = tbl_a[tbl_idx];
  assign tbl_data = tbl_d[tbl_idx];

  // slave knobs, written only by the tests
  bit          slave_rst;
  int          aw_delay, w_delay, slverr_at;
  bit          b_never, force_rd;
  logic [31:0] force_val;

  // slave state, written only by the slave process
  logic [31:0] mem [16];
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  int          aw_cnt, w_cnt, wr_count, aw_total, ar_total, vis_n;
  int          vis [8];
  bit          aw_got, w_got, b_pend, saw_aw_only, bad_strb;

  axi4_lite_cfg_sequencer #(
    .N_ENTRIES (16),
    .VERIFY    (1'b1),
    .TIMEOUT   (4)
  ) dut (
    .aclk (aclk), .aresetn (aresetn), .start (start), .n_entries (n_entries),
    .busy (busy), .done (done), .error (error), .err_code (err_code),
    .err_idx (err_idx), .tbl_idx (tbl_idx), .tbl_addr (tbl_addr), .tbl_data (tbl_data),
    .m_awvalid (m_awvalid), .m_awready (m_awready), .m_awaddr (m_awaddr),
    .m_wvalid (m_wvalid), .m_wready (m_wready), .m_wdata (m_wdata), .m_wstrb (m_wstrb),
    .m_bvalid (m_bvalid), .m_bready (m_bready), .m_bresp (m_bresp),
    .m_arvalid (m_arvalid), .m_arready (m_arready), .m_araddr (m_araddr),
    .m_rvalid (m_rvalid), .m_rready (m_rready), .m_rdata (m_rdata), .m_rresp (m_rresp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Slave: acts on falling edges so its responses are seen at the next rising
  // edge. A ready/valid it drove high on the previous falling edge has always
  // completed its handshake by the next falling edge.
  initial begin
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    aw_got = 0; w_got = 0; b_pend = 0; aw_cnt = 0; w_cnt = 0; wr_count = 0;
    aw_total = 0; ar_total = 0; vis_n = 0; saw_aw_only = 0; bad_strb = 0;
    cap_awaddr = 0; cap_wdata = 0; cap_araddr = 0;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    for (int i = 0; i < 8; i++) vis[i] = -1;
    forever begin
      @(negedge aclk);
      if (!aresetn || slave_rst) begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        aw_got = 0; w_got = 0; b_pend = 0; aw_cnt = 0; w_cnt = 0;
        if (slave_rst) begin
          wr_count = 0; aw_total = 0; ar_total = 0; vis_n = 0;
          saw_aw_only = 0; bad_strb = 0;
          for (int i = 0; i < 16; i++) mem[i] = 0;
          for (int i = 0; i < 8; i++) vis[i] = -1;
        end
      end else begin
        if (m_awvalid && !m_wvalid) saw_aw_only = 1;
        if (m_wvalid && m_wstrb != 4'hF) bad_strb = 1;
        if (m_bvalid) begin
          m_bvalid = 0; aw_got = 0; w_got = 0; b_pend = 0;
          aw_cnt = 0; w_cnt = 0; wr_count++;
        end
        if (m_awready) begin
          m_awready = 0; aw_got = 1; aw_total++;
        end else if (m_awvalid && !aw_got) begin
          if (aw_cnt >= aw_delay) begin
            m_awready = 1; cap_awaddr = m_awaddr;
            if (vis_n < 8) begin vis[vis_n] = int'(tbl_idx); vis_n++; end
          end else aw_cnt++;
        end
        if (m_wready) begin
          m_wready = 0; w_got = 1;
        end else if (m_wvalid && !w_got) begin
          if (w_cnt >= w_delay) begin m_wready = 1; cap_wdata = m_wdata; end
          else w_cnt++;
        end
        if (aw_got && w_got && !b_pend) begin
          b_pend = 1;
          mem[cap_awaddr[5:2]] = cap_wdata;
          if (!b_never) begin
            m_bvalid = 1;
            m_bresp = (wr_count == slverr_at) ? 2'b10 : 2'b00;
          end
        end
        if (m_rvalid) m_rvalid = 0;
        if (m_arready) begin
          m_arready = 0; ar_total++; m_rvalid = 1; m_rresp = 2'b00;
          m_rdata = force_rd ? force_val : mem[cap_araddr[5:2]];
        end else if (m_arvalid) begin
          m_arready = 1; cap_araddr = m_araddr;
        end
      end
    end
  end

  task automatic slave_clear();
    aw_delay = 0; w_delay = 0; slverr_at = -1; b_never = 0;
    force_rd = 0; force_val = 0;
    slave_rst = 1;
    repeat (2) @(negedge aclk);
    slave_rst = 0;
  endtask

  task automatic pulse_start(input logic [4:0] n);
    @(negedge aclk);
    n_entries = n; start = 1;
    @(negedge aclk);
    start = 0;
  endtask

  // Waits (bounded) for done; returns positioned on the negedge where done=1.
  task automatic wait_done(input int budget, output bit got, output bit gap, output int cyc);
    got = 0; gap = 0; cyc = 0;
    while (!got && cyc < budget) begin
      if (done) got = 1;
      else begin
        if (!busy) gap = 1;
        @(negedge aclk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge aclk);
    total++;
    if ({busy, done, error, err_code, err_idx, tbl_idx, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== '0) begin
      bad++; $display("[TB] FAIL reset_outputs: got busy=%b done=%b error=%b code=%0d awv=%b want all 0", busy, done, error, err_code, m_awvalid);
    end
    aresetn = 1;
    repeat (2) @(negedge aclk);
    total++;
    if ({busy, done, error, tbl_idx} !== '0) begin
      bad++; $display("[TB] FAIL reset_release: got busy=%b done=%b idx=%0d want 0", busy, done, tbl_idx);
    end
  endtask

  task automatic test_single();
    bit got, gap; int cyc;
    slave_clear();
    tbl_a[0] = 32'h0; tbl_d[0] = 32'hAAAA_AAAA;
    pulse_start(1);
    wait_done(100, got, gap, cyc);
    total++; if (got !== 1'b1) begin bad++; $display("[TB] FAIL single_done: got %b want 1", got); end
    total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL single_latency: got %0d want 5", cyc); end
    total++; if (gap !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_gap: got %b want 0", gap); end
    total++; if ({busy, error, err_code} !== 4'b0) begin bad++; $display("[TB] FAIL single_status: got busy=%b error=%b code=%0d want 0", busy, error, err_code); end
    total++; if (aw_total !== 1 || ar_total !== 1) begin bad++; $display("[TB] FAIL single_txn_count: got aw=%0d ar=%0d want 1/1", aw_total, ar_total); end
    total++; if (mem[0] !== 32'hAAAA_AAAA) begin bad++; $display("[TB] FAIL single_mem: got %h want aaaaaaaa", mem[0]); end
    total++; if (bad_strb !== 1'b0) begin bad++; $display("[TB] FAIL single_wstrb: got bad=%b want 0", bad_strb); end
    @(negedge aclk);
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL single_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_three_delayed_aw();
    bit got, gap; int cyc;
    slave_clear();
    aw_delay = 3;
    tbl_a[0] = 32'h04; tbl_d[0] = 32'h1111_1111;
    tbl_a[1] = 32'h08; tbl_d[1] = 32'h2222_2222;
    tbl_a[2] = 32'h0C; tbl_d[2] = 32'h3333_3333;
    pulse_start(3);
    wait_done(300, got, gap, cyc);
    total++; if (got !== 1'b1 || gap !== 1'b0) begin bad++; $display("[TB] FAIL three_done: got done=%b gap=%b want 1/0", got, gap); end
    total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL three_error: got %b want 0", error); end
    total++; if (mem[1] !== 32'h1111_1111 || mem[2] !== 32'h2222_2222 || mem[3] !== 32'h3333_3333) begin
      bad++; $display("[TB] FAIL three_mem: got %h %h %h want 11111111 22222222 33333333", mem[1], mem[2], mem[3]);
    end
    total++; if (vis_n !== 3 || vis[0] !== 0 || vis[1] !== 1 || vis[2] !== 2) begin
      bad++; $display("[TB] FAIL three_idx: got n=%0d %0d %0d %0d want 3: 0 1 2", vis_n, vis[0], vis[1], vis[2]);
    end
    total++; if (saw_aw_only !== 1'b1) begin bad++; $display("[TB] FAIL three_w_first: got %b want 1", saw_aw_only); end
    total++; if (aw_total !== 3 || ar_total !== 3) begin bad++; $display("[TB] FAIL three_txn_count: got aw=%0d ar=%0d want 3/3", aw_total, ar_total); end
  endtask

  task automatic test_slverr();
    bit got, gap; int cyc;
    slave_clear();
    slverr_at = 1;
    tbl_a[0] = 32'h20; tbl_d[0] = 32'h1234_5678;
    tbl_a[1] = 32'h24; tbl_d[1] = 32'h9ABC_DEF0;
    pulse_start(2);
    wait_done(200, got, gap, cyc);
    total++; if (got !== 1'b1) begin bad++; $display("[TB] FAIL slverr_done: got %b want 1", got); end
    total++; if ({error, err_code, err_idx} !== {1'b1, 2'd1, 4'd1}) begin
      bad++; $display("[TB] FAIL slverr_report: got error=%b code=%0d idx=%0d want 1/1/1", error, err_code, err_idx);
    end
    total++; if (aw_total !== 2 || ar_total !== 1) begin bad++; $display("[TB] FAIL slverr_txn_count: got aw=%0d ar=%0d want 2/1", aw_total, ar_total); end
  endtask

  task automatic test_mismatch();
    bit got, gap; int cyc;
    slave_clear();
    force_rd = 1; force_val = 32'h5555_5555;
    tbl_a[0] = 32'h10; tbl_d[0] = 32'hAAAA_AAAA;
    pulse_start(1);
    wait_done(100, got, gap, cyc);
    total++; if (got !== 1'b1) begin bad++; $display("[TB] FAIL mismatch_done: got %b want 1", got); end
    total++; if ({error, err_code, err_idx} !== {1'b1, 2'd2, 4'd0}) begin
      bad++; $display("[TB] FAIL mismatch_report: got error=%b code=%0d idx=%0d want 1/2/0", error, err_code, err_idx);
    end
  endtask

  task automatic test_timeout();
    bit got; int cyc, first_b, first_e;
    slave_clear();
    b_never = 1;
    tbl_a[0] = 32'h30; tbl_d[0] = 32'hDEAD_BEEF;
    pulse_start(1);
    got = 0; cyc = 0; first_b = -1; first_e = -1;
    while (!got && cyc < 100) begin
      if (m_bready && first_b < 0) first_b = cyc;
      if (error && first_e < 0) first_e = cyc;
      if (done) got = 1;
      else begin @(negedge aclk); cyc++; end
    end
    total++; if (got !== 1'b1) begin bad++; $display("[TB] FAIL timeout_done: got %b want 1", got); end
    total++; if ({error, err_code, err_idx} !== {1'b1, 2'd3, 4'd0}) begin
      bad++; $display("[TB] FAIL timeout_report: got error=%b code=%0d idx=%0d want 1/3/0", error, err_code, err_idx);
    end
    total++; if (first_b < 0 || first_e - first_b != 4) begin
      bad++; $display("[TB] FAIL timeout_delay: got wresp_at=%0d err_at=%0d want delta 4", first_b, first_e);
    end
    total++; if (ar_total !== 0 || m_bready !== 1'b0) begin bad++; $display("[TB] FAIL timeout_quiet: got ar=%0d bready=%b want 0/0", ar_total, m_bready); end
  endtask

  task automatic test_zero_entries();
    slave_clear();
    pulse_start(0);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_done: got done=%b busy=%b want 1/0", done, busy); end
    @(negedge aclk);
    total++; if (done !== 1'b0 || busy !== 1'b0 || aw_total !== 0) begin
      bad++; $display("[TB] FAIL zero_after: got done=%b busy=%b aw=%0d want 0/0/0", done, busy, aw_total);
    end
  endtask

  task automatic test_back_to_back();
    bit got, gap; int cyc;
    slave_clear();
    aw_delay = 3;
    tbl_a[0] = 32'h18; tbl_d[0] = 32'h0BAD_F00D;
    tbl_a[1] = 32'h1C; tbl_d[1] = 32'h600D_CAFE;
    pulse_start(2);
    repeat (3) @(negedge aclk);
    n_entries = 1; start = 1;
    @(negedge aclk);
    start = 0;
    wait_done(300, got, gap, cyc);
    total++; if (got !== 1'b1 || gap !== 1'b0) begin bad++; $display("[TB] FAIL busy_start_done: got done=%b gap=%b want 1/0", got, gap); end
    total++; if (aw_total !== 2 || error !== 1'b0) begin bad++; $display("[TB] FAIL busy_start_ignored: got aw=%0d error=%b want 2/0", aw_total, error); end
    total++; if (mem[6] !== 32'h0BAD_F00D || mem[7] !== 32'h600D_CAFE) begin
      bad++; $display("[TB] FAIL busy_start_mem: got %h %h want 0badf00d 600dcafe", mem[6], mem[7]);
    end
    n_entries = 1; start = 1;
    @(negedge aclk);
    start = 0;
    @(negedge aclk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL finish_start_ignored: got busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    slave_clear();
    aw_delay = 20;
    tbl_a[0] = 32'h3C; tbl_d[0] = 32'hCAFE_F00D;
    pulse_start(1);
    cyc = 0;
    while (!m_awvalid && cyc < 20) begin @(negedge aclk); cyc++; end
    total++; if (m_awvalid !== 1'b1) begin bad++; $display("[TB] FAIL midreset_reach_waddr: got %b want 1", m_awvalid); end
    #2 aresetn = 0;
    #1;
    total++;
    if ({busy, done, error, err_code, err_idx, tbl_idx, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== '0 ||
        m_awaddr !== 32'h0 || m_wdata !== 32'h0 || m_araddr !== 32'h0) begin
      bad++; $display("[TB] FAIL midreset_outputs: got busy=%b awv=%b wv=%b awaddr=%h wdata=%h want all 0", busy, m_awvalid, m_wvalid, m_awaddr, m_wdata);
    end
    repeat (2) @(negedge aclk);
    aresetn = 1;
    repeat (3) @(negedge aclk);
    total++; if (busy !== 1'b0 || m_awvalid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_idle: got busy=%b awv=%b want 0/0", busy, m_awvalid); end
  endtask

  initial begin
    total = 0; bad = 0;
    aresetn = 0; start = 0; n_entries = 0; slave_rst = 0;
    aw_delay = 0; w_delay = 0; slverr_at = -1; b_never = 0; force_rd = 0; force_val = 0;
    for (int i = 0; i < 16; i++) begin tbl_a[i] = 0; tbl_d[i] = 0; end
    test_reset();
    test_single();
    test_three_delayed_aw();
    test_slverr();
    test_mismatch();
    test_timeout();
    test_zero_entries();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_cfg_sequencer.md
Name: axi4_lite_cfg_sequencer

Overview:
Boot/reconfiguration engine that walks a table of (address, data) entries and issues AXI4-Lite writes to the dataplane CSR block.
With verification enabled, it reads each register back and compares the result.
Sits between the PS-side config logic, which supplies the table and the start pulse, and the CSR slave; it is the only AXI4-Lite master on that port.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width
N_ENTRIES, 16, max table depth
IDX_W, $clog2(N_ENTRIES), table index width
VERIFY, 1, 1 = read back and compare each entry
TIMEOUT, 255, max cycles waiting for B or R response

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
start  in  1  pulse; begins sequence when idle
n_entries  in  IDX_W+1  entries to process, sampled on start
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at completion, success or error
error  out  1  sticky error flag, cleared on next accepted start
err_code  out  2  0 none, 1 bad resp, 2 readback mismatch, 3 timeout
err_idx  out  IDX_W  index of failing entry
tbl_idx  out  IDX_W  current table index
tbl_addr  in  ADDR_W  entry address, combinational from tbl_idx
tbl_data  in  DATA_W  entry data, combinational from tbl_idx
m_awvalid/m_awready/m_awaddr  out/in/out  1/1/ADDR_W  write address channel
m_wvalid/m_wready/m_wdata/m_wstrb  out/in/out/out  1/1/DATA_W/DATA_W/8  write data channel, wstrb all ones
m_bvalid/m_bready/m_bresp  in/out/in  1/1/2  write response channel
m_arvalid/m_arready/m_araddr  out/in/out  1/1/ADDR_W  read address channel
m_rvalid/m_rready/m_rdata/m_rresp  in/out/in/in  1/1/DATA_W/2  read data channel

Behaviour:
- Reset: all outputs 0. FSM state is IDLE; index and timeout counters are 0.
- FSM states: IDLE, LOAD, WADDR, WRESP, RADDR, RDATA, FINISH.
- IDLE:
  - On start with n_entries == 0: go to FINISH; busy stays 0.
  - On start with n_entries > 0: clear error, err_code and err_idx; set tbl_idx = 0; busy = 1; go to LOAD.
- LOAD (1 cycle): register tbl_addr and tbl_data into internal regs; go to WADDR.
- WADDR:
  - Assert awvalid and wvalid together.
  - Each valid drops on its own handshake, independently; AW and W may complete in either order or in the same cycle.
  - Once both have completed, go to WRESP.
  - No timeout applies in this state.
- WRESP:
  - bready = 1.
  - On bvalid with bresp != OKAY: error, code 1.
  - On bvalid with OKAY: go to RADDR if VERIFY, otherwise advance.
- RADDR: arvalid = 1 until arready; then go to RDATA.
- RDATA:
  - rready = 1.
  - On rvalid with rresp != OKAY: code 1.
  - Otherwise, if rdata != latched data: code 2.
  - Otherwise advance.
- Timeout:
  - Counter clears on entry to WRESP/RDATA and counts every cycle without a response.
  - When it reaches TIMEOUT, flag code 3. Example: TIMEOUT = 4 raises the error 4 cycles after entry.
- Advance:
  - If tbl_idx == n_entries-1, go to FINISH.
  - Otherwise tbl_idx++ and go to LOAD.
  - tbl_idx never wraps.
- Error: set error = 1, err_code, err_idx = tbl_idx; go to FINISH. No further AXI traffic is issued.
- FINISH (1 cycle): done = 1, busy = 0; go to IDLE.
- Valid and ready outputs are registered. A valid is never dropped before its handshake.
- start while busy or in FINISH: ignored.
- Reset mid-transaction: immediate return to reset values. The slave side is assumed reset by the same aresetn.

Decomposition:
- axi4_lite_pkg holds:
  - resp_t: OKAY = 2'b00, EXOKAY = 01, SLVERR = 10, DECERR = 11
  - err_code_t
  - cfg_seq_state_t enum
  - shared AXI width localparams
- One sub-module: axi4_lite_single_master.
  - Takes a req/we/addr/wdata command and returns ack/rdata/resp.
  - Owns the AW/W/B/AR/R handshakes and the timeout counter.
  - The top FSM handles table walking, compare and error reporting.

Test Plan:
- Single entry {0x0, 0xAAAAAAAA}, VERIFY = 1, slave responds OKAY -> one write, then one read returning 0xAAAAAAAA; done pulses once; error = 0; busy high throughout.
- Three entries, slave delays awready 3 cycles but wready 0 -> wvalid drops first, awvalid held until awready; all three registers hold their values; tbl_idx visits 0, 1, 2.
- Entry 1 of 2 returns bresp = SLVERR -> error = 1, err_code = 1, err_idx = 1; no AR is issued; done pulses.
- Readback returns 0x55555555 against expected 0xAAAAAAAA -> err_code = 2, err_idx = 0.
- Slave never asserts bvalid, TIMEOUT = 4 -> err_code = 3 four cycles after entering WRESP.
- Boundary checks:
  - start with n_entries = 0 -> done on the next cycle with no AXI activity.
  - start pulsed while busy -> ignored.
  - aresetn asserted mid-WADDR -> all outputs 0 asynchronously.
